// File: rtl/text_pixel_fetch_if.sv
// Memory-side bus of the text pixel fetch stage.
// master: the fetch stage, which drives the VRAM and font ROM read addresses.
// slave : the memory side, which returns the data one cycle after the address.
//   vram_addr  [VRAM_AW] VRAM word address
//   vram_rdata [16]      {invert, code[6:0], fg_idx[3:0], bg_idx[3:0]}
//   font_addr  [11]      {code[6:0], glyph_row[3:0]}
//   font_rdata [8]       glyph row; bit 7 is the leftmost pixel
interface text_pixel_fetch_if #(
  parameter int unsigned VRAM_AW = 12
);
  logic [VRAM_AW-1:0] vram_addr;
  logic [15:0]        vram_rdata;
  logic [10:0]        font_addr;
  logic [7:0]         font_rdata;

  modport master (
    output vram_addr,
    output font_addr,
    input  vram_rdata,
    input  font_rdata
  );

  modport slave (
    input  vram_addr,
    input  font_addr,
    output vram_rdata,
    output font_rdata
  );
endinterface

// File: rtl/text_pixel_fetch.sv
// Text-mode pixel fetch: maps the VGA scan position (80x30 cells, 8x16 glyphs)
// to a glyph bit, the cell invert flag and fg/bg RGB444 colours for the colour
// mapper. Three-cycle pipeline with no stalls; sync and vde travel alongside.
// Ports:
//   pixel_clk, reset                 clock, synchronous active-high reset
//   drawX, drawY, vde_in, hsync_in, vsync_in   scan position and timing
//   mem (text_pixel_fetch_if.master) VRAM / font ROM synchronous read buses
//   pal_we, pal_waddr, pal_wdata     16-entry RGB444 palette write port
//   cursor_pos                       cursor cell index (CURSOR_BLINK_EN only)
//   pixel_data, invert, fg, bg       registered pixel outputs, 0 while blanked
//   vde_out, hsync_out, vsync_out    timing inputs delayed by 3 cycles
// Optional feature macro: CURSOR_BLINK_EN (blinking cursor by invert toggle).
module text_pixel_fetch #(
  parameter int unsigned COLS           = 80,
  parameter int unsigned ROWS           = 30,
  parameter int unsigned VRAM_AW        = 12,
  parameter int unsigned BLINK_DIV_LOG2 = 5
) (
  input  logic               pixel_clk,
  input  logic               reset,
  input  logic [9:0]         drawX,
  input  logic [9:0]         drawY,
  input  logic               vde_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  text_pixel_fetch_if.master mem,
  input  logic               pal_we,
  input  logic [3:0]         pal_waddr,
  input  logic [11:0]        pal_wdata,
  input  logic [VRAM_AW-1:0] cursor_pos,
  output logic               pixel_data,
  output logic               invert,
  output logic [11:0]        fg,
  output logic [11:0]        bg,
  output logic               vde_out,
  output logic               hsync_out,
  output logic               vsync_out
);

  // S0: cell index from the character row/column
  logic [4:0]         w_row;
  logic [6:0]         w_col;
  logic [VRAM_AW-1:0] w_cell;

  assign w_row = drawY[8:4];
  assign w_col = drawX[9:3];

  generate
    if (COLS == 80) begin : g_addr_shift
      // row*80 = row*64 + row*16
      assign w_cell = (VRAM_AW'(w_row) << 6) + (VRAM_AW'(w_row) << 4) + VRAM_AW'(w_col);
    end else begin : g_addr_mul
      assign w_cell = VRAM_AW'(32'(w_row) * COLS) + VRAM_AW'(w_col);
    end
  endgenerate

  assign mem.vram_addr = w_cell;

  // Stage registers
  logic [2:0]  r_xoff_d1, r_xoff_d2;
  logic [3:0]  r_row_d1;
  logic        r_vde_d1, r_vde_d2;
  logic        r_hs_d1, r_hs_d2;
  logic        r_vs_d1, r_vs_d2;
  logic        r_inv_d2;
  logic [3:0]  r_fgi_d2, r_bgi_d2;
  logic [11:0] r_pal [16];

  logic        w_inv_s1;
  logic        w_bit;
  logic [11:0] w_fg, w_bg;

  // S1: glyph row address from the returned character word
  assign mem.font_addr = {mem.vram_rdata[14:8], r_row_d1};

`ifdef CURSOR_BLINK_EN
  localparam int unsigned CNT_W = BLINK_DIV_LOG2 + 1;

  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_vsync_prev;
  logic             r_cur_d1;

  // Frame counter on vsync rising edges; cursor hit resolved at S0
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_frame_cnt  <= '0;
      r_vsync_prev <= 1'b0;
      r_cur_d1     <= 1'b0;
    end else begin
      r_vsync_prev <= vsync_in;
      if (vsync_in && !r_vsync_prev) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
      r_cur_d1 <= (w_cell == cursor_pos) && r_frame_cnt[BLINK_DIV_LOG2];
    end
  end

  assign w_inv_s1 = mem.vram_rdata[15] ^ r_cur_d1;

  logic w_unused;
  assign w_unused = ^{drawY[9], 1'(ROWS)};
`else
  assign w_inv_s1 = mem.vram_rdata[15];

  logic w_unused;
  assign w_unused = ^{drawY[9], cursor_pos, 1'(ROWS), 1'(BLINK_DIV_LOG2)};
`endif

  // S2: pixel bit select (bit 7 is leftmost) and palette lookup
  assign w_bit = mem.font_rdata[3'd7 - r_xoff_d2];
  assign w_fg  = r_pal[r_fgi_d2];
  assign w_bg  = r_pal[r_bgi_d2];

  // Palette register file; a write lands after this cycle's read
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        r_pal[i] <= '0;
      end
    end else if (pal_we) begin
      r_pal[pal_waddr] <= pal_wdata;
    end
  end

  // Pipeline S0 -> S3
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_xoff_d1  <= '0;
      r_row_d1   <= '0;
      r_vde_d1   <= 1'b0;
      r_hs_d1    <= 1'b0;
      r_vs_d1    <= 1'b0;
      r_xoff_d2  <= '0;
      r_vde_d2   <= 1'b0;
      r_hs_d2    <= 1'b0;
      r_vs_d2    <= 1'b0;
      r_inv_d2   <= 1'b0;
      r_fgi_d2   <= '0;
      r_bgi_d2   <= '0;
      pixel_data <= 1'b0;
      invert     <= 1'b0;
      fg         <= '0;
      bg         <= '0;
      vde_out    <= 1'b0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
    end else begin
      r_xoff_d1 <= drawX[2:0];
      r_row_d1  <= drawY[3:0];
      r_vde_d1  <= vde_in;
      r_hs_d1   <= hsync_in;
      r_vs_d1   <= vsync_in;

      r_xoff_d2 <= r_xoff_d1;
      r_vde_d2  <= r_vde_d1;
      r_hs_d2   <= r_hs_d1;
      r_vs_d2   <= r_vs_d1;
      r_inv_d2  <= w_inv_s1;
      r_fgi_d2  <= mem.vram_rdata[7:4];
      r_bgi_d2  <= mem.vram_rdata[3:0];

      vde_out   <= r_vde_d2;
      hsync_out <= r_hs_d2;
      vsync_out <= r_vs_d2;
      // Blanked pixels are forced to zero
      if (r_vde_d2) begin
        pixel_data <= w_bit;
        invert     <= r_inv_d2;
        fg         <= w_fg;
        bg         <= w_bg;
      end else begin
        pixel_data <= 1'b0;
        invert     <= 1'b0;
        fg         <= '0;
        bg         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_text_pixel_fetch.sv
// Directed bench for text_pixel_fetch with behavioural VRAM / font ROM.
module tb_text_pixel_fetch;

  logic        pixel_clk = 1'b0;
  logic        reset;
  logic [9:0]  drawX, drawY;
  logic        vde_in, hsync_in, vsync_in;
  logic        pal_we;
  logic [3:0]  pal_waddr;
  logic [11:0] pal_wdata;
  logic [11:0] cursor_pos;
  logic        pixel_data, invert, vde_out, hsync_out, vsync_out;
  logic [11:0] fg, bg;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] vram_mem [4096];
  logic [7:0]  font_mem [2048];

  text_pixel_fetch_if #(.VRAM_AW(12)) bus ();

  text_pixel_fetch #(
    .COLS(80), .ROWS(30), .VRAM_AW(12), .BLINK_DIV_LOG2(1)
  ) dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .drawX     (drawX),
    .drawY     (drawY),
    .vde_in    (vde_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .mem       (bus),
    .pal_we    (pal_we),
    .pal_waddr (pal_waddr),
    .pal_wdata (pal_wdata),
    .cursor_pos(cursor_pos),
    .pixel_data(pixel_data),
    .invert    (invert),
    .fg        (fg),
    .bg        (bg),
    .vde_out   (vde_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Synchronous-read memories, one cycle latency
  always @(posedge pixel_clk) begin
    bus.vram_rdata <= vram_mem[bus.vram_addr];
    bus.font_rdata <= font_mem[bus.font_addr];
  end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) vram_mem[i] = 16'h0000;
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'h00;
    vram_mem[0] = 16'h4121;          // 'A', fg 2, bg 1
    vram_mem[1] = 16'h4230;          // 'B', fg 3, bg 0
    vram_mem[2] = 16'hC230;          // 'B', inverted
    vram_mem[4] = 16'h4310;          // 'C', fg 1
    vram_mem[5] = 16'h4310;          // cursor cell
    font_mem[11'h410] = 8'b1000_0001;
    font_mem[11'h420] = 8'hFF;
    font_mem[11'h430] = 8'hFF;

    reset = 1'b1; drawX = '0; drawY = '0;
    vde_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b0;
    pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0; cursor_pos = 12'd5;
    tick(); tick(); tick();
    chk("rst_pixel", 32'(pixel_data), 32'd0);
    chk("rst_fg", 32'(fg), 32'd0);
    chk("rst_bg", 32'(bg), 32'd0);
    chk("rst_vde", 32'(vde_out), 32'd0);
    chk("rst_hsync", 32'(hsync_out), 32'd0);

    // Release reset, load palette
    reset = 1'b0; vde_in = 1'b0;
    pal_we = 1'b1; pal_waddr = 4'd1; pal_wdata = 12'h00A;
    tick();
    pal_waddr = 4'd2; pal_wdata = 12'h0B0;
    tick();
    pal_we = 1'b0;

    // Latency: cell 0 at (0,0)
    drawX = 10'd0; drawY = 10'd0; vde_in = 1'b1;
    #1;
    chk("vram_addr_0", 32'(bus.vram_addr), 32'd0);
    tick();
    chk("font_addr_A", 32'(bus.font_addr), 32'h410);
    tick();
    chk("vde_lat2", 32'(vde_out), 32'd0);
    tick();
    chk("first_pixel", 32'(pixel_data), 32'd1);
    chk("first_fg", 32'(fg), 32'h0B0);
    chk("first_bg", 32'(bg), 32'h00A);
    chk("first_vde", 32'(vde_out), 32'd1);
    chk("first_inv", 32'(invert), 32'd0);

    // Bit select across the 8 pixels of glyph row 0x81
    for (int c = 0; c <= 10; c++) begin
      drawX = (c < 8) ? 10'(c) : 10'd0;
      #1;
      if (c >= 3) chk($sformatf("bitsel_%0d", c - 3), 32'(pixel_data),
                      ((c - 3 == 0) || (c - 3 == 7)) ? 32'd1 : 32'd0);
      tick();
    end

    // Blanking and sync delay
    drawX = 10'd0; vde_in = 1'b0; hsync_in = 1'b0;
    tick(); tick();
    chk("blank_pre_vde", 32'(vde_out), 32'd1);
    chk("blank_pre_hs", 32'(hsync_out), 32'd1);
    chk("blank_pre_pix", 32'(pixel_data), 32'd1);
    tick();
    chk("blank_vde", 32'(vde_out), 32'd0);
    chk("blank_hs", 32'(hsync_out), 32'd0);
    chk("blank_pix", 32'(pixel_data), 32'd0);
    chk("blank_fg", 32'(fg), 32'd0);
    chk("blank_bg", 32'(bg), 32'd0);

    // Address arithmetic; load pal[3] meanwhile
    hsync_in = 1'b1;
    pal_we = 1'b1; pal_waddr = 4'd3; pal_wdata = 12'hF00;
    drawX = 10'd639; drawY = 10'd479;
    #1;
    chk("vram_addr_2399", 32'(bus.vram_addr), 32'd2399);
    tick();
    pal_we = 1'b0;
    drawX = 10'd8; drawY = 10'd16;
    #1;
    chk("vram_addr_81", 32'(bus.vram_addr), 32'd81);
    drawX = 10'd7; drawY = 10'd15;
    #1;
    chk("vram_addr_edge0", 32'(bus.vram_addr), 32'd0);

    // Palette write colliding with the S2 read of entry 3
    tick();
    drawX = 10'd8; drawY = 10'd0; vde_in = 1'b1;
    tick(); tick();
    pal_we = 1'b1; pal_waddr = 4'd3; pal_wdata = 12'h0F0;
    tick();
    pal_we = 1'b0;
    chk("coll_old_fg", 32'(fg), 32'hF00);
    chk("coll_pixel", 32'(pixel_data), 32'd1);
    tick();
    chk("coll_new_fg", 32'(fg), 32'h0F0);

    // Invert flag from VRAM
    drawX = 10'd16;
    tick(); tick(); tick();
    chk("invert_cell2", 32'(invert), 32'd1);
    chk("invert_fg", 32'(fg), 32'h0F0);

    // Reset for one cycle in active video
    reset = 1'b1;
    tick();
    chk("mid_rst_pix", 32'(pixel_data), 32'd0);
    chk("mid_rst_inv", 32'(invert), 32'd0);
    chk("mid_rst_fg", 32'(fg), 32'd0);
    chk("mid_rst_vde", 32'(vde_out), 32'd0);
    chk("mid_rst_hs", 32'(hsync_out), 32'd0);
    reset = 1'b0;
    tick(); tick();
    chk("mid_rst_vde_m3", 32'(vde_out), 32'd0);
    tick();
    chk("mid_rst_vde_back", 32'(vde_out), 32'd1);
    chk("mid_rst_pix_back", 32'(pixel_data), 32'd1);
    chk("mid_rst_inv_back", 32'(invert), 32'd1);
    chk("mid_rst_pal_clr", 32'(fg), 32'd0);

`ifdef CURSOR_BLINK_EN
    // Cursor at cell 5 blinks with frame-counter bit 1
    for (int k = 0; k < 6; k++) begin
      drawX = 10'd40;
      tick(); tick(); tick();
      chk($sformatf("cursor_f%0d", k), 32'(invert), 32'((k >> 1) & 1));
      drawX = 10'd32;
      tick(); tick(); tick();
      chk($sformatf("other_f%0d", k), 32'(invert), 32'd0);
      vsync_in = 1'b1;
      tick();
      vsync_in = 1'b0;
      tick();
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/text_pixel_fetch.md
Name: text_pixel_fetch

Overview:
- Stage directly upstream of the text colour mapper: turns the VGA scan position into per-pixel `pixel_data`, `invert`, `fg` and `bg` for that mapper.
- Text mode is 80x30 characters with 8x16 glyphs on a 640x480 raster.
- Pipeline steps: read the character word from VRAM (synchronous BRAM), read the glyph row from the font ROM (synchronous), select the pixel bit, look up fg/bg in a 16-entry palette.
- Syncs and data-enable are delayed to stay aligned with the pixel data.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, character rows
- VRAM_AW, 12, VRAM word address width (COLS*ROWS must be at most 2**VRAM_AW)
- BLINK_DIV_LOG2, 5, cursor blink half-period as log2 of a frame count (optional feature only)

Ports:
- pixel_clk  in  1  pixel clock; all state is on its rising edge
- reset  in  1  synchronous, active-high reset
- drawX  in  10  current pixel column from the VGA controller
- drawY  in  10  current pixel row from the VGA controller
- vde_in  in  1  active-video enable, aligned with drawX/drawY
- hsync_in  in  1  horizontal sync, aligned with drawX
- vsync_in  in  1  vertical sync, aligned with drawX
- vram_addr  out  VRAM_AW  VRAM read address
- vram_rdata  in  16  VRAM word, valid 1 cycle after address
  - [15] invert, [14:8] char code, [7:4] fg index, [3:0] bg index
- font_addr  out  11  font ROM address = {code[6:0], glyph row[3:0]}
- font_rdata  in  8  glyph row, valid 1 cycle after address; bit 7 is the leftmost pixel
- pal_we  in  1  palette write strobe
- pal_waddr  in  4  palette entry to write
- pal_wdata  in  12  RGB444 value
- cursor_pos  in  VRAM_AW  cell index of the cursor (used only with CURSOR_BLINK_EN)
- pixel_data  out  1  glyph bit for the current pixel
- invert  out  1  invert flag for the current cell
- fg  out  12  foreground RGB444
- bg  out  12  background RGB444
- vde_out  out  1  vde_in delayed by 3 cycles
- hsync_out  out  1  hsync_in delayed by 3 cycles
- vsync_out  out  1  vsync_in delayed by 3 cycles

Behaviour:
- Pipeline, one pixel per cycle, no stalls:
  - S0 (comb): vram_addr = (drawY[8:4])*COLS + drawX[9:3], computed with shifts and adds ((r<<6)+(r<<4)) and truncated to VRAM_AW; drawX[2:0], drawY[3:0] and the sync/vde bits are registered.
  - S1: font_addr = {vram_rdata[14:8], row_d1}; invert/fg index/bg index registered alongside.
  - S2: bit = font_rdata[7 - xoff_d2]; palette read.
  - S3: outputs registered.
- Latency: drawX/drawY presented at cycle n produce outputs at cycle n+3. vde/hsync/vsync use the same 3-stage delay so everything stays aligned.
- Blanking: when the S3-aligned vde is 0, pixel_data=0, invert=0, fg=0, bg=0. VRAM and ROM addresses still toggle; they are don't-care.
- Out-of-range positions: drawX>=640 or drawY>=480 only occur with vde_in=0. No clamping is performed.
- Palette:
  - 16x12 register file, reset to 0.
  - Write takes effect the cycle after pal_we.
  - Same-cycle read and write of the same entry returns the old value; the new value appears on the next pixel.
- Reset:
  - All pipeline registers, outputs and palette entries clear to 0. The sync delay registers also clear to 0, so sync outputs read as active-low-asserted during reset; the downstream encoder tolerates this.
  - Reset asserted mid-frame clears everything within 1 cycle; valid output resumes 3 cycles after release.
- Outputs are registered only; no combinational path from inputs to pixel outputs.

Optional Feature:
- Macro: CURSOR_BLINK_EN
- Defined:
  - A frame counter increments on each vsync_in rising edge.
  - Blink phase = bit BLINK_DIV_LOG2 of the counter.
  - When the S0 cell index equals cursor_pos and the phase is 1, the delivered invert is XORed with 1.
  - Counter resets to 0.
- Undefined: the counter and compare logic are absent, cursor_pos is ignored, and invert = vram_rdata[15] delayed.

Test Plan:
- Latency and blanking:
  - Stimulus: after reset, vde_in=1, drawX=0, drawY=0, VRAM[0]=16'h41_21 style word {0,'A',2,1}.
  - Required: vram_addr=0, font_addr={7'h41,4'h0}, outputs at +3 cycles with fg=pal[2], bg=pal[1], vde_out=1; with vde_in=0, all outputs are 0.
- Address arithmetic: drawX=639, drawY=479 -> vram_addr=29*80+79=2399.
  - Then drawX=8, drawY=16 -> 81.
- Bit select:
  - Stimulus: font_rdata=8'b1000_0001, drawX[2:0] stepping 0..7 over consecutive cycles.
  - Required: pixel_data sequence 1,0,0,0,0,0,0,1, delayed 3 cycles.
- Palette write/read collision:
  - Stimulus: pal[3]=12'hF00, then pal_we to entry 3 with 12'h0F0 on the same cycle S2 reads entry 3.
  - Required: that pixel shows 12'hF00 and the next pixel shows 12'h0F0.
- Reset mid-frame: assert reset for 1 cycle during active video -> all outputs 0 next cycle; valid pixels reappear 3 cycles after release.
- CURSOR_BLINK_EN:
  - Stimulus: BLINK_DIV_LOG2=1, cursor_pos=5, VRAM[5] invert=0.
  - Required: invert at cell 5 is 0 for frames 0-1, 1 for frames 2-3, then 0 again; other cells are unaffected.
